tst_probe_router: RTL and testbench

// Parametrised test-probe router for the testboard: N_IN asynchronous timing/interrupt

---
 rtl/tst_probe_router.sv | 149 ++++++++++++++
 tb/tb_tst_probe_router.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tst_probe_router.sv
// Test-probe router: synchronises N_IN async strobes and routes any of them to
// any of N_OUT test pins, each with its own select, display mode and a
// saturating rising-edge event counter. Also drives an OR-of-strobes flag.

// One output lane: routing select, display mode, stretch timer, toggle bit, counter.
module tst_probe_lane #(
  parameter int             N_IN    = 16,
  parameter int             SEL_W   = 8,
  parameter int             STRETCH = 8,
  parameter int             CNT_W   = 16,
  parameter logic [SEL_W-1:0] RST_SEL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  s2,
  input  logic [N_IN-1:0]  rise,
  input  logic             wr,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [1:0]       cfg_mode,
  output logic             probe,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [7:0] STR = STRETCH[7:0];

  logic [SEL_W-1:0] sel_q;
  logic [1:0]       mode_q;
  logic [7:0]       timer, timer_nxt;
  logic             tog, tog_nxt;
  logic             x, r;

  // Input mux; a select beyond N_IN matches nothing, so x = r = 0.
  always_comb begin
    x = 1'b0;
    r = 1'b0;
    for (int i = 0; i < N_IN; i++)
      if (sel_q == SEL_W'(i)) begin
        x = s2[i];
        r = rise[i];
      end
    timer_nxt = r ? STR : ((timer != 8'd0) ? timer - 8'd1 : 8'd0);
    tog_nxt   = tog ^ r;
  end

  // Lane state; a config write clears counter/timer/toggle and beats a coincident rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= RST_SEL;
      mode_q <= 2'b00;
      timer  <= 8'd0;
      tog    <= 1'b0;
      cnt    <= '0;
      probe  <= 1'b0;
    end else begin
      case (mode_q)
        2'b00:   probe <= x;
        2'b01:   probe <= (timer_nxt != 8'd0);
        2'b10:   probe <= tog_nxt;
        default: probe <= 1'b0;
      endcase
      if (wr) begin
        sel_q  <= cfg_sel;
        mode_q <= cfg_mode;
        timer  <= 8'd0;
        tog    <= 1'b0;
        cnt    <= '0;
      end else begin
        timer <= timer_nxt;
        tog   <= tog_nxt;
        if (r && (cnt != {CNT_W{1'b1}})) cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module tst_probe_router #(
  parameter int              N_IN     = 16,
  parameter int              N_OUT    = 2,
  parameter int              SEL_W    = 8,
  parameter int              OUT_W    = 4,
  parameter int              STRETCH  = 8,
  parameter int              CNT_W    = 16,
  parameter logic [N_IN-1:0] ACT_MASK = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  sig_in,
  input  logic             cfg_we,
  input  logic [OUT_W-1:0] cfg_idx,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [1:0]       cfg_mode,
  input  logic [OUT_W-1:0] cnt_idx,
  output logic [N_OUT-1:0] probe_out,
  output logic [CNT_W-1:0] cnt_out,
  output logic             act_or
);
  logic [N_IN-1:0]             s1, s2, s3, rise;
  logic [2:0]                  vld_pipe;
  logic [N_OUT-1:0]            wr;
  logic [N_OUT-1:0][CNT_W-1:0] cnt_all;
  logic [CNT_W-1:0]            cnt_sel;

  // Synchroniser plus edge-detect stage; vld_pipe marks when s3 holds a real
  // synchronised sample, so inputs already high at reset release never count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      vld_pipe <= '0;
      act_or   <= 1'b0;
    end else begin
      s1       <= sig_in;
      s2       <= s1;
      s3       <= s2;
      vld_pipe <= {vld_pipe[1:0], 1'b1};
      act_or   <= |(s2 & ACT_MASK);
    end
  end

  assign rise = s2 & ~s3 & {N_IN{vld_pipe[2]}};

  genvar k;
  generate
    for (k = 0; k < N_OUT; k++) begin : g_lane
      assign wr[k] = cfg_we && (cfg_idx == OUT_W'(k));
      tst_probe_lane #(
        .N_IN(N_IN), .SEL_W(SEL_W), .STRETCH(STRETCH), .CNT_W(CNT_W),
        .RST_SEL(SEL_W'(k))
      ) u_lane (
        .clk(clk), .rst_n(rst_n), .s2(s2), .rise(rise), .wr(wr[k]),
        .cfg_sel(cfg_sel), .cfg_mode(cfg_mode),
        .probe(probe_out[k]), .cnt(cnt_all[k])
      );
    end
  endgenerate

  // Counter readback mux; out-of-range index reads as zero.
  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < N_OUT; i++)
      if (cnt_idx == OUT_W'(i)) cnt_sel = cnt_all[i];
  end

  // Registered counter readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_out <= '0;
    else        cnt_out <= cnt_sel;
  end
endmodule

// File: tb/tb_tst_probe_router.sv
// Directed bench for tst_probe_router: N_IN=16, N_OUT=2, STRETCH=8, CNT_W=4.
module tb_tst_probe_router;
  localparam int N_IN = 16, N_OUT = 2, SEL_W = 8, OUT_W = 4, STRETCH = 8, CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_IN-1:0]  sig_in;
  logic             cfg_we;
  logic [OUT_W-1:0] cfg_idx;
  logic [SEL_W-1:0] cfg_sel;
  logic [1:0]       cfg_mode;
  logic [OUT_W-1:0] cnt_idx;
  logic [N_OUT-1:0] probe_out;
  logic [CNT_W-1:0] cnt_out;
  logic             act_or;

  int checks = 0;
  int fails  = 0;
  int hi, runs;

  tst_probe_router #(
    .N_IN(N_IN), .N_OUT(N_OUT), .SEL_W(SEL_W), .OUT_W(OUT_W),
    .STRETCH(STRETCH), .CNT_W(CNT_W), .ACT_MASK('1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cnt_idx(cnt_idx),
    .probe_out(probe_out), .cnt_out(cnt_out), .act_or(act_or)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [OUT_W-1:0] idx, input logic [SEL_W-1:0] sel, input logic [1:0] mode);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_mode = mode;
    step(1);
    cfg_we = 1'b0;
  endtask

  // Pulses sig_in[5] at cycle 0 and optionally at cycle p2; measures probe_out[1].
  task automatic run_stretch(input int p2, output int h, output int rn);
    logic prev;
    prev = 1'b0; h = 0; rn = 0;
    for (int c = 0; c < 30; c++) begin
      sig_in[5] = (c == 0) || (c == p2);
      step(1);
      if (probe_out[1]) h++;
      if (probe_out[1] && !prev) rn++;
      prev = probe_out[1];
    end
  endtask

  initial begin
    rst_n = 1'b0; sig_in = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0;
    cfg_mode = 2'b00; cnt_idx = '0;
    step(2);
    chk("rst_probe", probe_out, 2'b00);
    chk("rst_cnt", cnt_out, 0);
    chk("rst_act", act_or, 0);
    rst_n = 1'b1;
    step(4);

    // 1: direct mode, 3-edge latency
    sig_in[0] = 1'b1;
    step(2);
    chk("t1_p0_early", probe_out[0], 0);
    step(1);
    chk("t1_p0", probe_out[0], 1);
    chk("t1_p1", probe_out[1], 0);
    chk("t1_act", act_or, 1);
    step(1);
    chk("t1_cnt", cnt_out, 1);
    sig_in[0] = 1'b0;
    step(4);

    // 2: stretch, single pulse -> 8 cycles
    cfg(1, 5, 2'b01);
    run_stretch(-1, hi, runs);
    chk("t2_hi", hi, 8);
    chk("t2_runs", runs, 1);

    // 3: retrigger after 4 cycles -> 12 cycles, one run
    run_stretch(4, hi, runs);
    chk("t3_hi", hi, 12);
    chk("t3_runs", runs, 1);

    // 4: toggle mode, 3 pulses -> 1,0,1; counter 3
    cfg(0, 3, 2'b10);
    for (int p = 0; p < 3; p++) begin
      sig_in[3] = 1'b1; step(1);
      sig_in[3] = 1'b0; step(4);
      chk($sformatf("t4_tog%0d", p), probe_out[0], (p == 1) ? 0 : 1);
    end
    cnt_idx = 0;
    step(2);
    chk("t4_cnt", cnt_out, 3);

    // 5: saturation at 15, then cfg write beating a same-edge rise
    for (int p = 0; p < 20; p++) begin
      sig_in[3] = 1'b1; step(1);
      sig_in[3] = 1'b0; step(1);
    end
    step(4);
    chk("t5_sat", cnt_out, 15);
    sig_in[3] = 1'b1;
    step(2);
    cfg(0, 3, 2'b00);
    sig_in[3] = 1'b0;
    step(2);
    chk("t5_clear", cnt_out, 0);
    sig_in[3] = 1'b1; step(1);
    sig_in[3] = 1'b0; step(4);
    chk("t5_recount", cnt_out, 1);

    // 6: out-of-range select and out-of-range cfg index
    cfg(0, 20, 2'b00);
    cfg(1, 5, 2'b00);
    sig_in = '1;
    step(4);
    chk("t6_p0_off", probe_out[0], 0);
    chk("t6_p1_on", probe_out[1], 1);
    sig_in = '0;
    step(4);
    cnt_idx = 0; step(2);
    chk("t6_cnt0_frozen", cnt_out, 0);
    cnt_idx = 1; step(2);
    chk("t6_cnt1", cnt_out, 1);
    cfg(3, 0, 2'b11);
    sig_in = '1;
    step(4);
    chk("t6_p1_kept", probe_out[1], 1);
    chk("t6_p0_kept", probe_out[0], 0);
    step(2);
    chk("t6_cnt1_kept", cnt_out, 2);
    cnt_idx = 3; step(2);
    chk("t6_cnt_oor", cnt_out, 0);

    // Async reset mid-activity; inputs held high through release must not count
    cnt_idx = 1;
    step(2);
    rst_n = 1'b0;
    #1;
    chk("ar_probe", probe_out, 2'b00);
    chk("ar_cnt", cnt_out, 0);
    chk("ar_act", act_or, 0);
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("ar_rel_probe", probe_out, 2'b11);
    chk("ar_rel_act", act_or, 1);
    chk("ar_rel_cnt", cnt_out, 0);
    sig_in = '0;
    step(4);
    sig_in[1] = 1'b1;
    step(5);
    chk("ar_first_rise", cnt_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
